rob: RTL

ROB -- requirements
Module: rob

---
 rtl/rob_pkg.sv | 26 ++
 rtl/rob_if.sv | 54 +++++
 rtl/rob.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/rob_pkg.sv
// Shared reorder-buffer constants, instruction type and entry state encodings.
package rob_pkg;

  localparam int ROB_SIZE  = 8;
  localparam int ROB_WIDTH = 3;
  localparam logic [ROB_WIDTH:0] ROB_FULL_CNT = (ROB_WIDTH+1)'(ROB_SIZE);

  typedef enum logic [1:0] {
    T_REG    = 2'd0,
    T_BRANCH = 2'd1,
    T_STORE  = 2'd2,
    T_RSVD   = 2'd3
  } dec_type_e;

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'd0,
    ST_ISSUED = 2'd1,
    ST_DONE   = 2'd2
  } ent_state_e;

  // Advance a circular pointer; the pointer width makes 7 wrap to 0.
  function automatic logic [ROB_WIDTH-1:0] ptr_inc(input logic [ROB_WIDTH-1:0] p);
    return p + 1'b1;
  endfunction

endpackage

// File: rtl/rob_if.sv
// Decode, broadcast, query and commit signal bundle of the reorder buffer.
interface rob_if;
  import rob_pkg::*;

  logic                 rdy_in;
  logic                 dec_ready;
  logic [1:0]           dec_type;
  logic [4:0]           dec_rd;
  logic [31:0]          dec_pred_pc;
  logic                 rob_full;
  logic [ROB_WIDTH-1:0] rob_tail_id;
  logic                 rs_ready;
  logic [ROB_WIDTH-1:0] rs_rob_id;
  logic [31:0]          rs_value;
  logic                 lsb_ready;
  logic [ROB_WIDTH-1:0] lsb_rob_id;
  logic [31:0]          lsb_value;
  logic [ROB_WIDTH-1:0] query_j_id;
  logic [ROB_WIDTH-1:0] query_k_id;
  logic                 query_j_ready;
  logic                 query_k_ready;
  logic [31:0]          query_j_value;
  logic [31:0]          query_k_value;
  logic                 commit_valid;
  logic [4:0]           commit_rd;
  logic [31:0]          commit_value;
  logic [ROB_WIDTH-1:0] commit_rob_id;
  logic                 commit_store;
  logic                 clear;
  logic [31:0]          clear_pc;

  // Surrounding pipeline side: drives decode, broadcasts and queries.
  modport master (
    output rdy_in, dec_ready, dec_type, dec_rd, dec_pred_pc,
    output rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    output query_j_id, query_k_id,
    input  rob_full, rob_tail_id, query_j_ready, query_k_ready,
    input  query_j_value, query_k_value,
    input  commit_valid, commit_rd, commit_value, commit_rob_id,
    input  commit_store, clear, clear_pc
  );

  // Reorder buffer side.
  modport slave (
    input  rdy_in, dec_ready, dec_type, dec_rd, dec_pred_pc,
    input  rs_ready, rs_rob_id, rs_value, lsb_ready, lsb_rob_id, lsb_value,
    input  query_j_id, query_k_id,
    output rob_full, rob_tail_id, query_j_ready, query_k_ready,
    output query_j_value, query_k_value,
    output commit_valid, commit_rd, commit_value, commit_rob_id,
    output commit_store, clear, clear_pc
  );

endinterface

// File: rtl/rob.sv
// Eight-entry reorder buffer: in-order issue/commit, out-of-order writeback,
// operand bypass queries and branch-mispredict flush.
module rob
  import rob_pkg::*;
(
  input logic   clk_in,
  input logic   rst_in,
  rob_if.slave  bus
);

  ent_state_e           state_q [ROB_SIZE];
  logic [1:0]           type_q  [ROB_SIZE];
  logic [4:0]           rd_q    [ROB_SIZE];
  logic [31:0]          value_q [ROB_SIZE];
  logic [31:0]          pred_q  [ROB_SIZE];

  logic [ROB_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_WIDTH:0]   count_q, count_d;

  logic                 commit_valid_q, commit_store_q, clear_q;
  logic [4:0]           commit_rd_q;
  logic [31:0]          commit_value_q, clear_pc_q;
  logic [ROB_WIDTH-1:0] commit_rob_id_q;

  logic full, active, do_issue, do_commit, rs_wb, lsb_wb, mispredict;

  assign full = (count_q == ROB_FULL_CNT);

  // Qualify issue/writeback/commit and compute pointer/count next state.
  always_comb begin
    active     = bus.rdy_in && !clear_q;
    do_issue   = active && bus.dec_ready && !full;
    rs_wb      = active && bus.rs_ready && (state_q[bus.rs_rob_id] == ST_ISSUED);
    lsb_wb     = active && bus.lsb_ready && (state_q[bus.lsb_rob_id] == ST_ISSUED) &&
                 !(rs_wb && (bus.rs_rob_id == bus.lsb_rob_id));
    do_commit  = active && (state_q[head_q] == ST_DONE);
    mispredict = do_commit && (type_q[head_q] == T_BRANCH) &&
                 (value_q[head_q] != pred_q[head_q]);
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (clear_q) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (do_commit) head_d = ptr_inc(head_q);
      if (do_issue)  tail_d = ptr_inc(tail_q);
      count_d = count_q + {{ROB_WIDTH{1'b0}}, do_issue} - {{ROB_WIDTH{1'b0}}, do_commit};
    end
  end

  // Pointers, count and entry states; a pending flush always completes.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_SIZE; i++) state_q[i] <= ST_EMPTY;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (clear_q) begin
        for (int i = 0; i < ROB_SIZE; i++) state_q[i] <= ST_EMPTY;
      end else begin
        if (rs_wb)     state_q[bus.rs_rob_id]  <= ST_DONE;
        if (lsb_wb)    state_q[bus.lsb_rob_id] <= ST_DONE;
        if (do_commit) state_q[head_q]         <= ST_EMPTY;
        if (do_issue)  state_q[tail_q] <= (bus.dec_type == T_STORE) ? ST_DONE : ST_ISSUED;
      end
    end
  end

  // Entry payload; only meaningful while the entry state says so, so no reset.
  always_ff @(posedge clk_in) begin
    if (do_issue) begin
      type_q[tail_q] <= bus.dec_type;
      rd_q[tail_q]   <= bus.dec_rd;
      pred_q[tail_q] <= bus.dec_pred_pc;
    end
    if (rs_wb)  value_q[bus.rs_rob_id]  <= bus.rs_value;
    if (lsb_wb) value_q[bus.lsb_rob_id] <= bus.lsb_value;
  end

  // Registered commit/flush pulses, one cycle wide.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      commit_valid_q  <= 1'b0;
      commit_store_q  <= 1'b0;
      clear_q         <= 1'b0;
      commit_rd_q     <= '0;
      commit_value_q  <= '0;
      commit_rob_id_q <= '0;
      clear_pc_q      <= '0;
    end else begin
      commit_valid_q <= 1'b0;
      commit_store_q <= 1'b0;
      clear_q        <= 1'b0;
      if (do_commit) begin
        if (type_q[head_q] == T_REG) begin
          commit_valid_q  <= 1'b1;
          commit_rd_q     <= rd_q[head_q];
          commit_value_q  <= value_q[head_q];
          commit_rob_id_q <= head_q;
        end else if (type_q[head_q] == T_STORE) begin
          commit_store_q  <= 1'b1;
          commit_rob_id_q <= head_q;
        end
        if (mispredict) begin
          clear_q    <= 1'b1;
          clear_pc_q <= value_q[head_q];
        end
      end
    end
  end

  // Operand lookup: live broadcast wins (rs over lsb), then stored DONE value.
  always_comb begin
    bus.query_j_ready = 1'b0;
    bus.query_j_value = '0;
    bus.query_k_ready = 1'b0;
    bus.query_k_value = '0;
    if (bus.rs_ready && bus.rs_rob_id == bus.query_j_id) begin
      bus.query_j_ready = 1'b1;
      bus.query_j_value = bus.rs_value;
    end else if (bus.lsb_ready && bus.lsb_rob_id == bus.query_j_id) begin
      bus.query_j_ready = 1'b1;
      bus.query_j_value = bus.lsb_value;
    end else if (state_q[bus.query_j_id] == ST_DONE) begin
      bus.query_j_ready = 1'b1;
      bus.query_j_value = value_q[bus.query_j_id];
    end
    if (bus.rs_ready && bus.rs_rob_id == bus.query_k_id) begin
      bus.query_k_ready = 1'b1;
      bus.query_k_value = bus.rs_value;
    end else if (bus.lsb_ready && bus.lsb_rob_id == bus.query_k_id) begin
      bus.query_k_ready = 1'b1;
      bus.query_k_value = bus.lsb_value;
    end else if (state_q[bus.query_k_id] == ST_DONE) begin
      bus.query_k_ready = 1'b1;
      bus.query_k_value = value_q[bus.query_k_id];
    end
  end

  assign bus.rob_full      = full;
  assign bus.rob_tail_id   = tail_q;
  assign bus.commit_valid  = commit_valid_q;
  assign bus.commit_rd     = commit_rd_q;
  assign bus.commit_value  = commit_value_q;
  assign bus.commit_rob_id = commit_rob_id_q;
  assign bus.commit_store  = commit_store_q;
  assign bus.clear         = clear_q;
  assign bus.clear_pc      = clear_pc_q;

endmodule
